// File: rtl/serializador_p2s_if.sv
// Byte-stream link between the 2:1 lane mux and the serializer.
// The mux drives data/valid and watches ready; the serializer consumes.
interface serializador_p2s_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready;

  modport master (
    output data_in,
    output valid_in,
    input  ready
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready
  );
endinterface

// File: rtl/serializador_p2s.sv
// Parallel-to-serial stage: sends a COM preamble after reset, then one byte per
// 8 clks MSB first, substituting IDLE_CHAR for any slot without a valid byte.
module serializador_p2s #(
  parameter logic [7:0]  COM_CHAR   = 8'hBC,
  parameter logic [7:0]  IDLE_CHAR  = 8'h7C,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  serializador_p2s_if.slave bus,
  output logic              data_out,
  output logic              load,
  output logic              sync_done
);

  localparam logic [0:0] ST_SYNC   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

  logic [0:0] state_reg,     state_next;
  logic [2:0] bit_cnt_reg,   bit_cnt_next;
  logic [3:0] sync_cnt_reg,  sync_cnt_next;
  logic [7:0] shift_reg,     shift_next;
  logic       load_reg,      load_next;
  logic       sync_done_reg, sync_done_next;

  logic       load_edge;
  logic [7:0] shifted;

  assign load_edge = (bit_cnt_reg == 3'd0);

  // Left shift with zero fill; bit 7 is always the bit on the wire.
  assign shifted[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_shift
      assign shifted[gi] = shift_reg[gi-1];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg + 3'd1;
    sync_cnt_next  = sync_cnt_reg;
    shift_next     = shifted;
    load_next      = 1'b0;
    sync_done_next = sync_done_reg;

    if (load_edge) begin
      if (state_reg == ST_SYNC) begin
        shift_next    = COM_CHAR;
        sync_cnt_next = sync_cnt_reg + 4'd1;
        // Leave SYNC on the edge that loads the last COM of the preamble.
        if (sync_cnt_reg == SYNC_LAST) begin
          state_next     = ST_ACTIVE;
          sync_done_next = 1'b1;
        end
      end else if (bus.valid_in) begin
        shift_next = bus.data_in;
        load_next  = 1'b1;
      end else begin
        shift_next = IDLE_CHAR;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_SYNC;
      bit_cnt_reg   <= 3'd0;
      sync_cnt_reg  <= 4'd0;
      shift_reg     <= 8'h00;
      load_reg      <= 1'b0;
      sync_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      sync_cnt_reg  <= sync_cnt_next;
      shift_reg     <= shift_next;
      load_reg      <= load_next;
      sync_done_reg <= sync_done_next;
    end
  end

  assign bus.ready = (state_reg == ST_ACTIVE) && load_edge;
  assign data_out  = shift_reg[7];
  assign load      = load_reg;
  assign sync_done = sync_done_reg;

endmodule

// File: tb/tb_serializador_p2s.sv
// Randomized bench for serializador_p2s: two instances (4-COM and 1-COM preamble)
// checked bit by bit against a slot-based queue model of the serial stream.
module tb_serializador_p2s;

  localparam int SC_A = 4;
  localparam int SC_B = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  serializador_p2s_if bus ();
  serializador_p2s_if bus1 ();

  logic dout_a, load_a, sd_a;
  logic dout_b, load_b, sd_b;

  assign bus1.data_in  = bus.data_in;
  assign bus1.valid_in = bus.valid_in;

  serializador_p2s #(.SYNC_COUNT(SC_A)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .data_out  (dout_a),
    .load      (load_a),
    .sync_done (sd_a)
  );

  serializador_p2s #(.SYNC_COUNT(SC_B)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus1),
    .data_out  (dout_b),
    .load      (load_b),
    .sync_done (sd_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int edges = 0;
  bit q_a[$];
  bit q_b[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Byte the link must carry in a given slot since reset release.
  function automatic logic [7:0] slot_byte(input int slot, input int sc,
                                           input logic v, input logic [7:0] d);
    if (slot < sc) return 8'hBC;
    if (v)         return d;
    return 8'h7C;
  endfunction

  // One clock: drive inputs in the low phase, check ready, take the edge, check outputs.
  task automatic cycle(input logic v, input logic [7:0] d);
    bit         lo;
    int         slot;
    logic [7:0] ba, bb;
    bit         ea, eb;
    bus.valid_in = v;
    bus.data_in  = d;
    #1;
    lo   = (edges % 8 == 0);
    slot = edges / 8;
    check("ready_a", {31'd0, bus.ready},  {31'd0, lo && slot >= SC_A});
    check("ready_b", {31'd0, bus1.ready}, {31'd0, lo && slot >= SC_B});
    @(posedge clk);
    #1;
    edges++;
    if (lo) begin
      ba = slot_byte(slot, SC_A, v, d);
      bb = slot_byte(slot, SC_B, v, d);
      for (int i = 7; i >= 0; i--) begin
        q_a.push_back(ba[i]);
        q_b.push_back(bb[i]);
      end
      $display("slot %0d: A sends %02h, B sends %02h (valid=%0b)", slot, ba, bb, v);
    end
    ea = (q_a.size() > 0) ? q_a.pop_front() : 1'b0;
    eb = (q_b.size() > 0) ? q_b.pop_front() : 1'b0;
    check("dout_a", {31'd0, dout_a}, {31'd0, ea});
    check("dout_b", {31'd0, dout_b}, {31'd0, eb});
    check("load_a", {31'd0, load_a}, {31'd0, lo && slot >= SC_A && v});
    check("load_b", {31'd0, load_b}, {31'd0, lo && slot >= SC_B && v});
    check("sync_done_a", {31'd0, sd_a}, {31'd0, ((edges - 1) / 8 + 1) >= SC_A});
    check("sync_done_b", {31'd0, sd_b}, {31'd0, ((edges - 1) / 8 + 1) >= SC_B});
    @(negedge clk);
  endtask

  task automatic rand_cycle();
    cycle(1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  // Offer a byte at a load edge, then scramble the inputs for the other 7 clks.
  task automatic byte_slot(input logic v, input logic [7:0] d);
    cycle(v, d);
    repeat (7) rand_cycle();
  endtask

  task automatic align_load();
    while (edges % 8 != 0) rand_cycle();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dout_a"}, {31'd0, dout_a}, 32'd0);
    check({tag, "_dout_b"}, {31'd0, dout_b}, 32'd0);
    check({tag, "_load_a"}, {31'd0, load_a}, 32'd0);
    check({tag, "_sd_a"},   {31'd0, sd_a},   32'd0);
    check({tag, "_sd_b"},   {31'd0, sd_b},   32'd0);
    check({tag, "_rdy_a"},  {31'd0, bus.ready},  32'd0);
    check({tag, "_rdy_b"},  {31'd0, bus1.ready}, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    edges = 0;
    q_a.delete();
    q_b.delete();
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    release_reset();

    // Preamble with no data offered, then idle filler.
    repeat (48) cycle(1'b0, 8'($urandom));

    // Single byte surrounded by idle slots.
    align_load();
    cycle(1'b1, 8'hA5);
    repeat (15) cycle(1'b0, 8'($urandom));

    // Back-to-back bytes with junk between load edges.
    align_load();
    byte_slot(1'b1, 8'h00);
    byte_slot(1'b1, 8'hFF);
    byte_slot(1'b1, 8'h3C);

    repeat (40) byte_slot(1'($urandom_range(0, 1)), 8'($urandom));

    // Reset in the middle of an active byte, while a 1 is on the wire.
    align_load();
    cycle(1'b1, 8'hA5);
    repeat (5) cycle(1'b0, 8'($urandom));
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("midreset");
    repeat (2) @(negedge clk);
    release_reset();

    // Full preamble must reappear before any data, even with valid held high.
    repeat (48) cycle(1'b1, 8'($urandom));
    repeat (20) byte_slot(1'($urandom_range(0, 1)), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
